// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter.
//   ramstate_t  : RAM handshake state driven by the RAM (FREE, BUSY, ACCESS, ERROR).
//   arb_state_t : arbiter FSM states (idle, RAM access in flight, failed store-conditional).
//   arb_req_t   : one picked transaction: core index, data/instruction, write, atomic.
//   link_t      : LL/SC reservation {valid, addr}, used when ATOMIC_LINK_EN is defined.
package cpu_types_pkg;

  localparam int unsigned WordW = 32;

  typedef logic [WordW-1:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StScFail
  } arb_state_t;

  typedef struct packed {
    logic core;
    logic is_data;
    logic is_write;
    logic is_atomic;
  } arb_req_t;

  typedef struct packed {
    logic  valid;
    word_t addr;
  } link_t;

endpackage

// File: rtl/arb_picker.sv
// Combinational request picker for the two-core memory arbiter.
//   ireq_i, drd_i, dwr_i : per-core instruction read, data read, data write requests
//   datomic_i            : per-core atomic flag (LL on read, SC on write)
//   last_core_i          : core served by the previous transaction
//   req_o                : picked transaction (core, is_data, is_write, is_atomic)
//   valid_o              : at least one request is pending
// The core not served last is preferred; within a core the data port wins.
module arb_picker
  import cpu_types_pkg::*;
#(
  parameter int unsigned CPUS = 2
) (
  input  logic [CPUS-1:0] ireq_i,
  input  logic [CPUS-1:0] drd_i,
  input  logic [CPUS-1:0] dwr_i,
  input  logic [CPUS-1:0] datomic_i,
  input  logic            last_core_i,
  output arb_req_t        req_o,
  output logic            valid_o
);

  logic [CPUS-1:0] has_req;
  logic            pref;
  logic            core;

  always_comb begin
    has_req         = ireq_i | drd_i | dwr_i;
    pref            = ~last_core_i;
    core            = has_req[pref] ? pref : ~pref;
    req_o.core      = core;
    req_o.is_data   = drd_i[core] | dwr_i[core];
    // dREN together with dWEN counts as a write
    req_o.is_write  = dwr_i[core];
    req_o.is_atomic = datomic_i[core] & (drd_i[core] | dwr_i[core]);
    valid_o         = |has_req;
  end

endmodule

// File: rtl/memory_arbiter.sv
// Two-core memory arbiter: four cache ports (I and D per core) share one RAM port.
//   CLK, RST           : clock, synchronous active-high reset
//   iREN/iaddr         : instruction read requests; iload/iwait return data and stall
//   dREN/dWEN/datomic  : data read/write requests, datomic marks LL (read) / SC (write)
//   daddr/dstore       : data address and write data; dload/dwait return data and stall
//   ramREN/ramWEN      : registered RAM strobes; ramaddr/ramstore registered address/data
//   ramload/ramstate   : RAM read data and handshake state
// Optional feature macro ATOMIC_LINK_EN: per-core LL/SC reservation registers; a failing
// SC completes in one cycle through StScFail without touching RAM.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned CPUS   = 2,
  parameter int unsigned WORD_W = 32
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [CPUS-1:0]              iREN,
  input  logic [CPUS-1:0][WORD_W-1:0]  iaddr,
  output logic [CPUS-1:0][WORD_W-1:0]  iload,
  output logic [CPUS-1:0]              iwait,
  input  logic [CPUS-1:0]              dREN,
  input  logic [CPUS-1:0]              dWEN,
  input  logic [CPUS-1:0]              datomic,
  input  logic [CPUS-1:0][WORD_W-1:0]  daddr,
  input  logic [CPUS-1:0][WORD_W-1:0]  dstore,
  output logic [CPUS-1:0][WORD_W-1:0]  dload,
  output logic [CPUS-1:0]              dwait,
  output logic                         ramREN,
  output logic                         ramWEN,
  output logic [WORD_W-1:0]            ramaddr,
  output logic [WORD_W-1:0]            ramstore,
  input  logic [WORD_W-1:0]            ramload,
  input  ramstate_t                    ramstate
);

  arb_state_t        state_q, state_d;
  arb_req_t          grant_q, grant_d;
  arb_req_t          pick_req;
  logic              pick_valid;
  logic              last_core_q, last_core_d;
  logic              ram_ren_q, ram_ren_d;
  logic              ram_wen_q, ram_wen_d;
  logic [WORD_W-1:0] ram_addr_q, ram_addr_d;
  logic [WORD_W-1:0] ram_store_q, ram_store_d;
  logic              busy_done;
  logic              sc_fail;

  arb_picker #(
    .CPUS (CPUS)
  ) u_picker (
    .ireq_i      (iREN),
    .drd_i       (dREN),
    .dwr_i       (dWEN),
    .datomic_i   (datomic),
    .last_core_i (last_core_q),
    .req_o       (pick_req),
    .valid_o     (pick_valid)
  );

  // RST masks completion so an abandoned access never looks finished to a requester
  assign busy_done = (state_q == StBusy) && (ramstate == ACCESS) && !RST;

`ifdef ATOMIC_LINK_EN
  link_t [CPUS-1:0] link_q, link_d;

  assign sc_fail = pick_req.is_atomic && pick_req.is_write &&
                   !(link_q[pick_req.core].valid &&
                     (link_q[pick_req.core].addr == daddr[pick_req.core]));

  always_comb begin
    link_d = link_q;
    if (busy_done) begin
      if (grant_q.is_write) begin
        // any completed write kills matching reservations of both cores
        for (int c = 0; c < CPUS; c++) begin
          if (link_q[c].addr == ram_addr_q) begin
            link_d[c].valid = 1'b0;
          end
        end
        if (grant_q.is_atomic) begin
          link_d[grant_q.core].valid = 1'b0;
        end
      end else if (grant_q.is_data && grant_q.is_atomic) begin
        link_d[grant_q.core].valid = 1'b1;
        link_d[grant_q.core].addr  = ram_addr_q;
      end
    end
  end
`else
  logic unused_atomic;
  assign sc_fail       = 1'b0;
  assign unused_atomic = pick_req.is_atomic ^ grant_q.is_atomic;
`endif

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_core_d = last_core_q;
    ram_ren_d   = ram_ren_q;
    ram_wen_d   = ram_wen_q;
    ram_addr_d  = ram_addr_q;
    ram_store_d = ram_store_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d = pick_req;
          if (sc_fail) begin
            state_d = StScFail;
          end else begin
            state_d     = StBusy;
            ram_ren_d   = !pick_req.is_write;
            ram_wen_d   = pick_req.is_write;
            ram_addr_d  = pick_req.is_data ? daddr[pick_req.core] : iaddr[pick_req.core];
            ram_store_d = pick_req.is_write ? dstore[pick_req.core] : '0;
          end
        end
      end
      StBusy: begin
        // FREE, BUSY and ERROR all hold the grant and keep the strobe up
        if (busy_done) begin
          state_d     = StIdle;
          last_core_d = grant_q.core;
          ram_ren_d   = 1'b0;
          ram_wen_d   = 1'b0;
          ram_addr_d  = '0;
          ram_store_d = '0;
        end
      end
      StScFail: begin
        state_d     = StIdle;
        last_core_d = grant_q.core;
      end
      default: state_d = StIdle;
    endcase
  end

  // Return path to the requesters
  always_comb begin
    iwait = '1;
    dwait = '1;
    iload = '0;
    dload = '0;
    if (busy_done) begin
      if (grant_q.is_data) begin
        dwait[grant_q.core] = 1'b0;
        dload[grant_q.core] = grant_q.is_write ? {{(WORD_W-1){1'b0}}, 1'b1} : ramload;
      end else begin
        iwait[grant_q.core] = 1'b0;
        iload[grant_q.core] = ramload;
      end
    end else if ((state_q == StScFail) && !RST) begin
      dwait[grant_q.core] = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      last_core_q <= 1'b1;
      ram_ren_q   <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_store_q <= '0;
`ifdef ATOMIC_LINK_EN
      link_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_core_q <= last_core_d;
      ram_ren_q   <= ram_ren_d;
      ram_wen_q   <= ram_wen_d;
      ram_addr_q  <= ram_addr_d;
      ram_store_q <= ram_store_d;
`ifdef ATOMIC_LINK_EN
      link_q      <= link_d;
`endif
    end
  end

  assign ramREN   = ram_ren_q;
  assign ramWEN   = ram_wen_q;
  assign ramaddr  = ram_addr_q;
  assign ramstore = ram_store_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: a RAM responder model, a completion scoreboard
// per requester port and a RAM-access scoreboard, driven by a vector table plus
// hand-written multi-cycle sequences.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int CPUS = 2;
  localparam int W    = 32;
  localparam int KIf  = 0;
  localparam int KLd  = 1;
  localparam int KSt  = 2;
`ifdef ATOMIC_LINK_EN
  localparam bit AtomicEn = 1'b1;
`else
  localparam bit AtomicEn = 1'b0;
`endif

  logic                      CLK = 1'b0;
  logic                      RST;
  logic [CPUS-1:0]           iREN, iwait, dREN, dWEN, datomic, dwait;
  logic [CPUS-1:0][W-1:0]    iaddr, iload, daddr, dstore, dload;
  logic                      ramREN, ramWEN;
  logic [W-1:0]              ramaddr, ramstore, ramload;
  ramstate_t                 ramstate;

  memory_arbiter #(
    .CPUS   (CPUS),
    .WORD_W (W)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iload    (iload),
    .iwait    (iwait),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .datomic  (datomic),
    .daddr    (daddr),
    .dstore   (dstore),
    .dload    (dload),
    .dwait    (dwait),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  initial forever #5 CLK = ~CLK;

  typedef struct { int port; logic [31:0] data; } exp_t;
  typedef struct { logic wen; logic [31:0] addr; logic [31:0] store; } ramexp_t;
  typedef struct {
    int core; int kind; logic [31:0] addr; logic [31:0] store; int lat; logic [31:0] data;
  } vec_t;

  exp_t        exp_q[$];
  ramexp_t     ram_q[$];
  logic [31:0] mem [logic [31:0]];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          ram_lat = 1;
  int          ram_cnt = 0;
  int          err_left = 0;
  logic [3:0]  hold = '0;
  logic [3:0]  done_now = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_check(input int port, input logic [31:0] data);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_unexpected: port %0d completed with %h, nothing expected", port, data);
    end else begin
      e = exp_q.pop_front();
      chk("done_port", port, e.port);
      chk("done_data", data, e.data);
    end
  endtask

  task automatic monitor();
    ramexp_t r;
    done_now = '0;
    for (int c = 0; c < CPUS; c++) begin
      if (iwait[c] !== 1'b1) begin
        done_now[2*c] = 1'b1;
        sb_check(2*c, iload[c]);
        if (!hold[2*c]) iREN[c] = 1'b0;
      end
      if (dwait[c] !== 1'b1) begin
        done_now[2*c+1] = 1'b1;
        sb_check(2*c+1, dload[c]);
        if (!hold[2*c+1]) begin
          dREN[c] = 1'b0; dWEN[c] = 1'b0; datomic[c] = 1'b0;
        end
      end
    end
    if ((ramREN === 1'b1 || ramWEN === 1'b1) && ramstate == ACCESS) begin
      if (ram_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL ram_unexpected: access to %h, none expected", ramaddr);
      end else begin
        r = ram_q.pop_front();
        chk("ram_wen", ramWEN, r.wen);
        chk("ram_addr", ramaddr, r.addr);
        if (r.wen) chk("ram_store", ramstore, r.store);
      end
      if (ramWEN) mem[ramaddr] = ramstore;
    end
  endtask

  // One clock: RAM model responds just after the edge, checks run on the falling edge.
  task automatic step();
    @(posedge CLK);
    #1;
    if (ramREN || ramWEN) begin
      ram_cnt++;
      if (err_left > 0) begin
        ramstate = ERROR;
        err_left--;
      end else if (ram_cnt >= ram_lat) ramstate = ACCESS;
      else ramstate = BUSY;
    end else begin
      ram_cnt  = 0;
      ramstate = FREE;
    end
    ramload = mem.exists(ramaddr) ? mem[ramaddr] : ~ramaddr;
    @(negedge CLK);
    monitor();
  endtask

  task automatic issue(input int core, input int kind, input bit atomic,
                       input logic [31:0] addr, input logic [31:0] store);
    if (kind == KIf) begin
      iREN[core]  = 1'b1;
      iaddr[core] = addr;
    end else begin
      dREN[core]    = (kind == KLd);
      dWEN[core]    = (kind == KSt);
      datomic[core] = atomic;
      daddr[core]   = addr;
      dstore[core]  = store;
    end
  endtask

  task automatic expect_done(input int port, input logic [31:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic expect_ram(input logic wen, input logic [31:0] addr, input logic [31:0] store);
    ramexp_t r;
    r.wen = wen; r.addr = addr; r.store = store;
    ram_q.push_back(r);
  endtask

  task automatic wait_done(input string name, input int port, input int exp_steps);
    int n = 0;
    done_now = '0;
    while (!done_now[port] && n < 40) begin
      step();
      n++;
    end
    if (!done_now[port]) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: port %0d never completed, required %0d cycles", name, port,
               exp_steps);
    end else begin
      chk({name, "_latency"}, n, exp_steps);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   dstep[3];
    int   dcount;
    int   port;

    RST = 1'b1;
    iREN = '0; dREN = '0; dWEN = '0; datomic = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE;
    mem[32'h40] = 32'hDEADBEEF;
    mem[32'h44] = 32'h0BADF00D;
    step();
    step();
    RST = 1'b0;

    // Reset values
    chk("rst_ramren", ramREN, 1'b0);
    chk("rst_ramwen", ramWEN, 1'b0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_ramstore", ramstore, 32'h0);
    chk("rst_iwait", iwait, 2'b11);
    chk("rst_dwait", dwait, 2'b11);
    chk("rst_iload", iload, 64'h0);
    chk("rst_dload", dload, 64'h0);

    // Single fetch with ACCESS on the first BUSY cycle
    issue(0, KIf, 1'b0, 32'h40, 32'h0);
    expect_done(0, 32'hDEADBEEF);
    expect_ram(1'b0, 32'h40, 32'h0);
    step();
    chk("tp1_ramren_c1", ramREN, 1'b1);
    chk("tp1_done_c1", done_now[0], 1'b1);
    step();
    chk("tp1_ramren_c2", ramREN, 1'b0);
    chk("tp1_iwait_c2", iwait, 2'b11);

    // Table of single transactions
    vecs[0] = '{1, KIf, 32'h44,  32'h0,        2, 32'h0BADF00D};
    vecs[1] = '{0, KSt, 32'h80,  32'h5,        1, 32'h1};
    vecs[2] = '{1, KLd, 32'h80,  32'h0,        3, 32'h5};
    vecs[3] = '{0, KLd, 32'h200, 32'h0,        1, 32'hFFFFFDFF};
    vecs[4] = '{1, KSt, 32'h300, 32'h12345678, 2, 32'h1};
    vecs[5] = '{1, KIf, 32'h300, 32'h0,        1, 32'h12345678};
    vecs[6] = '{0, KIf, 32'h40,  32'h0,        4, 32'hDEADBEEF};
    for (int i = 0; i < 7; i++) begin
      ram_lat = vecs[i].lat;
      port    = 2 * vecs[i].core + ((vecs[i].kind != KIf) ? 1 : 0);
      issue(vecs[i].core, vecs[i].kind, 1'b0, vecs[i].addr, vecs[i].store);
      expect_done(port, vecs[i].data);
      expect_ram(vecs[i].kind == KSt, vecs[i].addr, vecs[i].store);
      wait_done("vec", port, vecs[i].lat);
      step();
      chk("vec_idle_strobe", {ramREN, ramWEN}, 2'b00);
    end

    // Contention, RAM latency 3, both cores hold dREN: core0, core1, core0
    RST = 1'b1;
    step();
    RST = 1'b0;
    ram_lat = 3;
    mem[32'h500] = 32'hAAAA0500;
    mem[32'h504] = 32'hBBBB0504;
    hold = 4'b1010;
    issue(0, KLd, 1'b0, 32'h500, 32'h0);
    issue(1, KLd, 1'b0, 32'h504, 32'h0);
    expect_done(1, 32'hAAAA0500);
    expect_done(3, 32'hBBBB0504);
    expect_done(1, 32'hAAAA0500);
    expect_ram(1'b0, 32'h500, 32'h0);
    expect_ram(1'b0, 32'h504, 32'h0);
    expect_ram(1'b0, 32'h500, 32'h0);
    dcount = 0;
    for (int s = 1; s <= 11; s++) begin
      step();
      if (done_now[1] || done_now[3]) begin
        if (dcount < 3) dstep[dcount] = s;
        dcount++;
      end
    end
    hold = '0;
    dREN = '0;
    chk("rr_count", dcount, 3);
    chk("rr_step0", dstep[0], 3);
    chk("rr_step1", dstep[1], 7);
    chk("rr_step2", dstep[2], 11);
    step();

    // Intra-core priority: data write beats instruction fetch
    ram_lat = 1;
    issue(1, KIf, 1'b0, 32'h84, 32'h0);
    issue(1, KSt, 1'b0, 32'h80, 32'h5);
    expect_done(3, 32'h1);
    expect_done(2, 32'hFFFFFF7B);
    expect_ram(1'b1, 32'h80, 32'h5);
    expect_ram(1'b0, 32'h84, 32'h0);
    step();
    chk("prio_ramwen", ramWEN, 1'b1);
    chk("prio_ramstore", ramstore, 32'h5);
    chk("prio_if_waits", iwait[1], 1'b1);
    wait_done("prio_if", 2, 2);
    step();

    // ERROR twice then ACCESS: single completion, no early wait drop
    issue(0, KIf, 1'b0, 32'h40, 32'h0);
    expect_done(0, 32'hDEADBEEF);
    expect_ram(1'b0, 32'h40, 32'h0);
    err_left = 2;
    step();
    chk("err_wait_c1", iwait[0], 1'b1);
    chk("err_ren_c1", ramREN, 1'b1);
    step();
    chk("err_wait_c2", iwait[0], 1'b1);
    step();
    chk("err_done_c3", done_now[0], 1'b1);
    step();
    chk("err_after_waits", iwait, 2'b11);

    // Reset in the middle of a RAM access
    ram_lat = 5;
    issue(0, KLd, 1'b0, 32'h40, 32'h0);
    step();
    step();
    chk("rstmid_busy_ren", ramREN, 1'b1);
    RST = 1'b1;
    step();
    chk("rstmid_ren", ramREN, 1'b0);
    chk("rstmid_wen", ramWEN, 1'b0);
    chk("rstmid_addr", ramaddr, 32'h0);
    chk("rstmid_dwait", dwait, 2'b11);
    chk("rstmid_iwait", iwait, 2'b11);
    RST = 1'b0;
    dREN = '0;
    step();
    chk("rstmid_state", dut.state_q, StIdle);
    chk("rstmid_idle_ren", ramREN, 1'b0);
    ram_lat = 1;

    // LL then SC to the same address succeeds
    issue(0, KLd, 1'b1, 32'h100, 32'h0);
    expect_done(1, 32'hFFFFFEFF);
    expect_ram(1'b0, 32'h100, 32'h0);
    wait_done("ll1", 1, 1);
    step();
    issue(0, KSt, 1'b1, 32'h100, 32'h7);
    expect_done(1, 32'h1);
    expect_ram(1'b1, 32'h100, 32'h7);
    step();
    chk("sc1_wen", ramWEN, 1'b1);
    chk("sc1_done", done_now[1], 1'b1);
    step();

    // LL, other core stores to the same address, then SC
    issue(0, KLd, 1'b1, 32'h100, 32'h0);
    expect_done(1, 32'h7);
    expect_ram(1'b0, 32'h100, 32'h0);
    wait_done("ll2", 1, 1);
    step();
    issue(1, KSt, 1'b0, 32'h100, 32'h9);
    expect_done(3, 32'h1);
    expect_ram(1'b1, 32'h100, 32'h9);
    wait_done("sw_other", 3, 1);
    step();
    issue(0, KSt, 1'b1, 32'h100, 32'h8);
    if (AtomicEn) begin
      expect_done(1, 32'h0);
    end else begin
      expect_done(1, 32'h1);
      expect_ram(1'b1, 32'h100, 32'h8);
    end
    step();
    chk("sc2_wen", ramWEN, AtomicEn ? 1'b0 : 1'b1);
    chk("sc2_ren", ramREN, 1'b0);
    chk("sc2_done_c1", done_now[1], 1'b1);
    step();
    chk("sc2_mem", mem[32'h100], AtomicEn ? 32'h9 : 32'h8);
    chk("sc2_idle_waits", dwait, 2'b11);

    chk("sb_drained", exp_q.size(), 0);
    chk("ram_sb_drained", ram_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
